// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: PS/2 set-2 scan codes -> ASCII, buffered in a show-ahead FIFO
// feeding the LC3 keyboard registers (kbd_rdy = KBSR[15], kbd_data = KBDR).
// Optional feature: define KBD_CTRL_EN to build the ctrl modifier; a letter
// typed with ctrl held then yields its control code (A -> 0x01 .. Z -> 0x1A).
module ps2_kbd_decoder #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_rdy,
  input  logic [8:0] ps2_cmd,
  input  logic       ps2_err,
  input  logic       kbd_rd,
  output logic       kbd_rdy,
  output logic [7:0] kbd_data,
  output logic       kbd_ovf
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} st_t;
  st_t st, st_nxt;

  logic [7:0] code;
  logic       acc;
  logic       make_ev, brk_ev, xmake_ev, xbrk_ev;
  logic       shift_l, shift_r, caps, caps_held, ctrl;
  logic [7:0] lc, dg, sy, sp, ch;
  logic       push, pop_ok, push_ok, full, empty;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0] mem [DEPTH];
  logic       unused_par;

  assign code       = ps2_cmd[7:0];
  assign unused_par = ps2_cmd[8];   // parity already checked upstream
  assign acc        = ps2_rdy & ~ps2_err;

  // prefix state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;

  // prefix next state; an errored byte drops any pending prefix
  always_comb begin
    st_nxt = st;
    if (ps2_rdy) begin
      if (ps2_err) st_nxt = IDLE;
      else case (st)
        IDLE:    st_nxt = (code == 8'hF0) ? BRK : (code == 8'hE0) ? EXT : IDLE;
        EXT:     st_nxt = (code == 8'hF0) ? EXT_BRK : IDLE;
        default: st_nxt = IDLE;
      endcase
    end
  end

  // event decode from the current prefix state
  always_comb begin
    make_ev  = acc && st == IDLE && code != 8'hF0 && code != 8'hE0;
    brk_ev   = acc && st == BRK;
    xmake_ev = acc && st == EXT && code != 8'hF0;
    xbrk_ev  = acc && st == EXT_BRK;
  end

  // shift / caps modifiers; caps_held stops typematic repeats re-toggling caps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shift_l <= 1'b0; shift_r <= 1'b0; caps <= 1'b0; caps_held <= 1'b0;
    end else begin
      if (make_ev && code == 8'h12) shift_l <= 1'b1;
      if (brk_ev  && code == 8'h12) shift_l <= 1'b0;
      if (make_ev && code == 8'h59) shift_r <= 1'b1;
      if (brk_ev  && code == 8'h59) shift_r <= 1'b0;
      if (make_ev && code == 8'h58) begin
        caps_held <= 1'b1;
        if (!caps_held) caps <= ~caps;
      end
      if (brk_ev && code == 8'h58) caps_held <= 1'b0;
    end

`ifdef KBD_CTRL_EN
  // ctrl follows both left (14) and right (E0 14) keys
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ctrl <= 1'b0;
    else if ((make_ev || xmake_ev) && code == 8'h14) ctrl <= 1'b1;
    else if ((brk_ev  || xbrk_ev)  && code == 8'h14) ctrl <= 1'b0;
`else
  logic unused_ext;
  assign unused_ext = xmake_ev | xbrk_ev;
  assign ctrl       = 1'b0;
`endif

  // scan code lookup: lowercase letter, digit/shifted symbol, or special
  always_comb begin
    lc = 8'h00; dg = 8'h00; sy = 8'h00; sp = 8'h00;
    case (code)
      8'h1C: lc = "a"; 8'h32: lc = "b"; 8'h21: lc = "c"; 8'h23: lc = "d";
      8'h24: lc = "e"; 8'h2B: lc = "f"; 8'h34: lc = "g"; 8'h33: lc = "h";
      8'h43: lc = "i"; 8'h3B: lc = "j"; 8'h42: lc = "k"; 8'h4B: lc = "l";
      8'h3A: lc = "m"; 8'h31: lc = "n"; 8'h44: lc = "o"; 8'h4D: lc = "p";
      8'h15: lc = "q"; 8'h2D: lc = "r"; 8'h1B: lc = "s"; 8'h2C: lc = "t";
      8'h3C: lc = "u"; 8'h2A: lc = "v"; 8'h1D: lc = "w"; 8'h22: lc = "x";
      8'h35: lc = "y"; 8'h1A: lc = "z";
      8'h45: begin dg = "0"; sy = ")"; end
      8'h16: begin dg = "1"; sy = "!"; end
      8'h1E: begin dg = "2"; sy = "@"; end
      8'h26: begin dg = "3"; sy = "#"; end
      8'h25: begin dg = "4"; sy = "$"; end
      8'h2E: begin dg = "5"; sy = "%"; end
      8'h36: begin dg = "6"; sy = "^"; end
      8'h3D: begin dg = "7"; sy = "&"; end
      8'h3E: begin dg = "8"; sy = "*"; end
      8'h46: begin dg = "9"; sy = "("; end
      8'h29: sp = 8'h20; 8'h5A: sp = 8'h0A; 8'h66: sp = 8'h08;
      8'h0D: sp = 8'h09; 8'h76: sp = 8'h1B;
      default: ;
    endcase
  end

  // character select from pre-edge modifiers; zero means nothing to push
  always_comb begin
    if (lc != 8'h00)
      ch = ctrl ? lc - 8'h60 : ((shift_l | shift_r) ^ caps) ? lc - 8'h20 : lc;
    else if (dg != 8'h00)
      ch = (shift_l | shift_r) ? sy : dg;
    else
      ch = sp;
  end

  assign push    = make_ev && ch != 8'h00;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign pop_ok  = kbd_rd && !empty;
  assign push_ok = push && (!full || pop_ok);

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0; rd_ptr <= '0; kbd_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop_ok) kbd_ovf <= 1'b1;
      else if (pop_ok)             kbd_ovf <= 1'b0;
    end

  // FIFO storage
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr[AW-1:0]] <= ch;

  assign kbd_rdy  = !empty;
  assign kbd_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder; expected characters are hand-computed.
module tb_ps2_kbd_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_rdy = 1'b0;
  logic [8:0] ps2_cmd = '0;
  logic       ps2_err = 1'b0;
  logic       kbd_rd = 1'b0;
  logic       kbd_rdy;
  logic [7:0] kbd_data;
  logic       kbd_ovf;
  int nvec = 0;
  int nerr = 0;

  logic [7:0] sp_code [5] = '{8'h66, 8'h0D, 8'h76, 8'h5A, 8'h29};
  logic [7:0] sp_exp  [5] = '{8'h08, 8'h09, 8'h1B, 8'h0A, 8'h20};
  logic [7:0] dg_code [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  ps2_kbd_decoder #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_rdy(ps2_rdy), .ps2_cmd(ps2_cmd),
    .ps2_err(ps2_err), .kbd_rd(kbd_rd), .kbd_rdy(kbd_rdy),
    .kbd_data(kbd_data), .kbd_ovf(kbd_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // one-cycle ps2_rdy pulse, optionally with a simultaneous pop
  task automatic send(input logic [7:0] c, input logic err = 1'b0, input logic rd = 1'b0);
    @(negedge clk);
    ps2_rdy = 1'b1; ps2_cmd = {1'b0, c}; ps2_err = err; kbd_rd = rd;
    @(negedge clk);
    ps2_rdy = 1'b0; ps2_err = 1'b0; kbd_rd = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk); kbd_rd = 1'b1;
    @(negedge clk); kbd_rd = 1'b0;
  endtask

  task automatic expect_char(input string tag, input logic [7:0] exp);
    chk({tag, "_rdy"}, kbd_rdy, 1);
    chk({tag, "_data"}, kbd_data, exp);
    pop();
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rdy", kbd_rdy, 0);
    chk("rst_data", kbd_data, 8'h00);
    chk("rst_ovf", kbd_ovf, 0);

    // single make + break
    send(8'h1C);
    chk("lat_rdy", kbd_rdy, 1);
    send(8'hF0); send(8'h1C);
    expect_char("a", 8'h61);
    chk("empty_rdy", kbd_rdy, 0);
    chk("empty_data", kbd_data, 8'h00);

    // shift then release
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    expect_char("shA", 8'h41);
    expect_char("a2", 8'h61);
    send(8'h58); send(8'hF0); send(8'h58); send(8'h32);
    expect_char("capsB", 8'h42);
    send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_nopush", kbd_rdy, 0);

    // held caps with repeats toggles once
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1A);
    expect_char("capsZ", 8'h5A);
    send(8'h12); send(8'h1A);
    expect_char("caps_shz", 8'h7A);
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58);

    // shifted digit, right shift, extended codes ignored
    send(8'h12); send(8'h16);
    expect_char("bang", 8'h21);
    send(8'hF0); send(8'h12);
    send(8'h59); send(8'h15); send(8'h45);
    expect_char("shrQ", 8'h51);
    expect_char("rparen", 8'h29);
    send(8'hF0); send(8'h59);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_nopush", kbd_rdy, 0);
    for (int i = 0; i < 5; i++) begin
      send(sp_code[i]);
      expect_char($sformatf("sp%0d", i), sp_exp[i]);
    end

    // overflow: 9 pushes into depth 8
    for (int i = 0; i < 9; i++) send(dg_code[i]);
    chk("ovf_set", kbd_ovf, 1);
    chk("ovf_head", kbd_data, 8'h31);
    send(8'h45, 1'b0, 1'b1);          // push '0' and pop '1' while full
    chk("ovf_clr", kbd_ovf, 0);
    for (int i = 1; i < 8; i++) expect_char($sformatf("fifo%0d", i), 8'h31 + 8'(i));
    expect_char("fifo_last", 8'h30);
    chk("drained", kbd_rdy, 0);
    pop();
    chk("pop_empty", kbd_rdy, 0);

    // push with pop on an empty FIFO: push wins
    send(8'h1C, 1'b0, 1'b1);
    expect_char("pp_empty", 8'h61);

    // errored F0 is dropped, so 1C is a make
    send(8'hF0, 1'b1); send(8'h1C);
    expect_char("err", 8'h61);

    // ctrl
    send(8'h14); send(8'h21);
`ifdef KBD_CTRL_EN
    expect_char("ctrlC", 8'h03);
`else
    expect_char("noctrl", 8'h63);
`endif
    send(8'hF0); send(8'h14);
    send(8'h21);
    expect_char("ctrl_rel", 8'h63);

    // reset mid-sequence drops prefix and FIFO contents
    send(8'h29); send(8'hF0);
    do_reset();
    chk("rst2_rdy", kbd_rdy, 0);
    send(8'h1C);
    expect_char("rst2_a", 8'h61);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_decoder.md
# ps2_kbd_decoder

Consumes the byte stream from the PS/2 receive stage and turns PS/2 scan code set 2 sequences into ASCII characters. It tracks make, break and extended prefixes and the shift, caps-lock and ctrl modifiers. Decoded characters are buffered in a small FIFO that backs the LC3 keyboard device registers (KBSR ready bit, KBDR data).

## Interface
Parameters:
- DEPTH, 8: FIFO depth in characters. Must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ps2_rdy  in  1  one-cycle pulse; `ps2_cmd` and `ps2_err` are valid in that cycle.
- ps2_cmd  in  9  received frame. [7:0] is the scan code byte; [8] is the parity bit and is ignored here.
- ps2_err  in  1  frame error qualifier, sampled only when `ps2_rdy` is high.
- kbd_rd  in  1  one-cycle pop pulse (LC3 read of KBDR).
- kbd_rdy  out  1  FIFO not empty (KBSR[15]).
- kbd_data  out  8  ASCII character at the FIFO head. Reads 8'h00 when empty.
- kbd_ovf  out  1  sticky flag: a character was dropped because the FIFO was full.

## Operation
- Prefix FSM: states IDLE, BRK, EXT, EXT_BRK. Transitions happen only on edges where `ps2_rdy` is high.
  - IDLE: code F0 -> BRK; code E0 -> EXT; any other code is a make event, stay in IDLE.
  - EXT: F0 -> EXT_BRK; any other code is an extended make -> IDLE.
  - BRK: any code is a break event -> IDLE.
  - EXT_BRK: any code is an extended break -> IDLE.
- `ps2_rdy` with `ps2_err` high: byte discarded, FSM forced to IDLE, modifiers unchanged, nothing pushed.
- Modifier registers:
  - shift_l (12) and shift_r (59): set on make, cleared on break.
  - ctrl (14, and E0 14): set on make, cleared on break.
  - caps: toggles on a make of 58 only while caps_held is clear. caps_held is set on make of 58 and cleared on break of 58, so typematic repeats do not toggle caps.
- Translation applies to non-extended make events only. Extended codes other than E0 14 are ignored.
  - Letters A–Z (standard set-2 codes, e.g. 1C=A, 1A=Z): uppercase when shift XOR caps, else lowercase.
  - Digits 0–9 (45, 16, 1E … 46): the digit, or with shift the US symbols `)!@#$%^&*(`.
  - 29 -> 0x20, 5A -> 0x0A, 66 -> 0x08, 0D -> 0x09, 76 -> 0x1B.
  - All other codes produce nothing.
- Typematic repeats (a repeated make without a break) each push a character.
- Break events never push.
- FIFO push occurs on the same edge as the accepted `ps2_rdy`. Translation is combinational from `ps2_cmd` and the pre-edge modifier state.
- Pop: on `kbd_rd` while non-empty, advance the read pointer. `kbd_rd` while empty is ignored.
- Full FIFO:
  - A push while full and no pop in the same cycle: character dropped, `kbd_ovf` set.
  - A push and a pop in the same cycle while full: both accepted, no overflow.
  - A push and a pop in the same cycle while empty: the push is accepted, the pop is ignored.
- `kbd_ovf` clears on the first accepted pop after it is set.
- Pointers are log2(DEPTH)+1 bits wide. Full and empty are distinguished by the extra MSB. Pointers wrap naturally.

## Timing
- Reset values:
  - FSM in IDLE.
  - All modifier registers and caps_held cleared.
  - Pointers 0.
  - `kbd_rdy` = 0, `kbd_data` = 8'h00, `kbd_ovf` = 0.
- Latency: `ps2_rdy` sampled at edge N. `kbd_rdy` and `kbd_data` are valid after edge N (the following cycle).
- `kbd_data` is show-ahead, driven combinationally from registered storage. It changes the cycle after an accepted pop.
- `kbd_rdy` falls the cycle after the pop that empties the FIFO.
- Reset asserted mid-sequence (e.g. after F0): the pending prefix is lost and FIFO contents are discarded.
- Back-to-back `ps2_rdy` pulses on consecutive cycles must be handled, although the upstream stage never produces them.

## Configuration
- KBD_CTRL_EN defined: while ctrl is set, a letter make pushes its control code (A -> 0x01 … Z -> 0x1A), overriding shift and caps. Digits and specials are unaffected.
- KBD_CTRL_EN undefined: the ctrl register is not built, codes 14 and E0 14 are ignored, and letters follow the shift/caps rule only.

## Test plan
- After reset, push 1C, then F0 1C -> exactly one char 0x61. `kbd_rdy` is 1 one cycle after the 1C pulse. Pop -> `kbd_rdy` is 0 and `kbd_data` is 0x00.
- Send 12, 1C, F0 1C, F0 12, 1C -> chars 0x41, 0x61. Then 58, F0 58, 32 -> 0x42.
- Send 58, 58, 58, F0 58 (held caps with repeats), then 1A -> caps toggled once; char 0x5A.
- Send 12, 16 -> 0x21. Send E0 75 (up arrow), E0 F0 75 -> nothing pushed. The FSM is back in IDLE, shown by a following 29 producing 0x20.
- With DEPTH=8, push 9 chars with no reads -> 8 stored, `kbd_ovf`=1, FIFO order preserved. Then a simultaneous push and pop while full -> accepted, count stays 8. The first pop clears `kbd_ovf`.
- Send F0 with `ps2_err`=1, then 1C -> 0x61 pushed (the error-flagged F0 is discarded, so 1C is a make). With KBD_CTRL_EN: 14, 21 -> 0x03.
